lcd_status_reader: RTL and testbench
====================================

Name: lcd_status_reader

Overview:
- Read-side companion to the team's 4-bit HD44780 LCD write controller on the Spartan-3E board (50 MHz).
- Performs 4-bit-mode LCD read transactions:
  - status read (RS=0): busy flag and address counter;
  - data read (RS=1): DDRAM/CGRAM byte.
- Optional poll mode repeats status reads until the busy flag clears, with a bounded retry count.
- The top level uses oLCD_BusRelease to tristate the shared data pins and to mux E/RS/RW between this block and the writer.

Parameters:
SETUP_CYCLES, 2, cycles RS/RW are stable before E rises (≥40 ns)
E_HIGH_CYCLES, 12, E high width per nibble (≥230 ns); data sampled in last E-high cycle
E_LOW_CYCLES, 50, E low time after each nibble (≥1 µs)
MAX_POLLS, 255, maximum status reads in poll mode before timeout (1..255)

Ports:
Clock  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
iStart  in  1  request a transaction; honoured only in IDLE
iRegisterSelect  in  1  0 = status read, 1 = data read; latched on accept
iPoll  in  1  1 = repeat status reads until BF=0; latched on accept; ignored when iRegisterSelect=1
iLCD_Data  in  4  LCD DB7..DB4 as driven by the LCD
oBusy  out  1  high from accept until the cycle after oDone
oDone  out  1  one-cycle pulse; result valid
oData  out  8  last byte read; held until next accept
oBusyFlag  out  1  equals oData[7]
oAddress  out  7  equals oData[6:0]
oTimeout  out  1  valid with oDone; 1 = poll exhausted MAX_POLLS with BF still 1
oLCD_Enabled  out  1  LCD E
oLCD_RegisterSelect  out  1  LCD RS
oLCD_ReadWrite  out  1  LCD R/W; 1 throughout a transaction
oLCD_BusRelease  out  1  equals oLCD_ReadWrite; top level tristates DB7..DB4 when 1

Behaviour:
- Reset: the only asynchronous behaviour is none; Reset is synchronous, active-high, and sampled on Clock.
- Reset values: state IDLE; counters 0; oBusy, oDone, oTimeout, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_BusRelease all 0; oData 8'h00.
- Reset mid-transaction: takes effect on the next edge; E drops immediately; no oDone pulse.
- States and durations: IDLE → SETUP (SETUP_CYCLES) → EH_HI (E_HIGH_CYCLES) → EL_HI (E_LOW_CYCLES) → EH_LO (E_HIGH_CYCLES) → EL_LO (E_LOW_CYCLES) → DONE (1 cycle) → IDLE.
- Each state lasts exactly its parameter count; the cycle counter clears on every state entry.
- Accept: iStart=1 in IDLE at edge k.
  - SETUP occupies cycles k+1 .. k+SETUP_CYCLES.
  - RS and RW drive from cycle k+1.
- Outputs by state:
  - E = 1 only in EH_HI and EH_LO.
  - RW and RS are held through EL_LO; both return to 0 in DONE.
- Sampling:
  - iLCD_Data is captured into a high-nibble register on the last cycle of EH_HI.
  - iLCD_Data is captured into a low-nibble register on the last cycle of EH_LO.
- oData update: on entry to DONE, the high and low nibble registers load into oData.
  - Poll iterations also update oData at the end of each read.
- Defaults, single read: oDone at cycle k+127 (2+12+50+12+50 = 126 cycles of transaction, then DONE).
- Poll mode:
  - At the end of EL_LO, if BF=1 and read count < MAX_POLLS: go back to SETUP and increment the count.
  - RW stays 1 across iterations, so the bus is not returned between polls.
  - Otherwise go to DONE, with oTimeout = BF.
- oBusy: high from k+1 through the DONE cycle.
- iStart outside IDLE: ignored, with no queuing; the same applies to an iStart in the DONE cycle.
- iStart held high continuously: a new transaction is accepted in the IDLE cycle following DONE.

Test Plan:
- Status read, LCD model drives 8'h85 (nibble 8 then 5), iStart pulse at k → E high for exactly 12 cycles twice with 50 low cycles between; oDone at k+127; oData=8'h85, oBusyFlag=1, oAddress=7'h05, oTimeout=0; RW=1 from k+1 through k+126.
- Data read, iRegisterSelect=1, model returns 8'h41 → RS=1 through EL_LO; oData=8'h41; iPoll=1 ignored, so exactly one read.
- Poll mode, model returns BF=1 for 3 reads then 8'h0C → four E-pulse pairs, oDone after 4×126+1 cycles, oData=8'h0C, oTimeout=0; RW never drops between reads.
- Poll timeout, MAX_POLLS=3, model always returns 8'h80 → exactly 3 reads, then oDone with oTimeout=1 and oData=8'h80.
- Reset asserted in the 5th cycle of EH_LO → next cycle E=0, RW=0, oBusy=0, no oDone; a fresh iStart afterwards completes normally.
- iStart pulses during EL_HI and in the DONE cycle → ignored; only one oDone per accepted start.

Source files
------------

// File: rtl/lcd_status_reader.sv
// lcd_status_reader: 4-bit HD44780 status/data read sequencer with optional busy-flag polling.
module lcd_status_reader #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int E_LOW_CYCLES  = 50,
  parameter int MAX_POLLS     = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRegisterSelect,
  input  logic       iPoll,
  input  logic [3:0] iLCD_Data,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oBusyFlag,
  output logic [6:0] oAddress,
  output logic       oTimeout,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_BusRelease
);
  typedef enum logic [2:0] {IDLE, SETUP, EH_HI, EL_HI, EH_LO, EL_LO, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, dur;
  logic [7:0] polls_q, polls_d, data_q, data_d;
  logic [3:0] hi_q, hi_d, lo_q, lo_d;
  logic rs_q, rs_d, poll_q, poll_d, timeout_q, timeout_d;
  logic e_q, e_d, rw_q, rw_d, rs_out_q, rs_out_d, busy_q, busy_d, done_q, done_d;
  logic last, again;
  assign dur = state_q == SETUP ? 16'(SETUP_CYCLES) :
               (state_q == EH_HI || state_q == EH_LO) ? 16'(E_HIGH_CYCLES) : 16'(E_LOW_CYCLES);
  assign last = cnt_q == dur - 16'd1;
  // hi_q[3] is the busy flag of the read that is just finishing
  assign again = poll_q && hi_q[3] && (int'(polls_q) + 1 < MAX_POLLS);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    polls_d   = polls_q;
    rs_d      = rs_q;
    poll_d    = poll_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (iStart) begin
          state_d = SETUP;
          rs_d    = iRegisterSelect;
          poll_d  = iPoll & ~iRegisterSelect;
          polls_d = '0;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: if (last) begin
        cnt_d = '0;
        case (state_q)
          SETUP: state_d = EH_HI;
          EH_HI: begin
            state_d = EL_HI;
            hi_d    = iLCD_Data;
          end
          EL_HI: state_d = EH_LO;
          EH_LO: begin
            state_d = EL_LO;
            lo_d    = iLCD_Data;
          end
          EL_LO: begin
            data_d = {hi_q, lo_q};
            if (again) begin
              state_d = SETUP;
              polls_d = polls_q + 8'd1;
            end else begin
              state_d   = DONE;
              timeout_d = poll_q & hi_q[3];
            end
          end
          default: state_d = IDLE;
        endcase
      end
    endcase
    e_d      = state_d == EH_HI || state_d == EH_LO;
    rw_d     = state_d != IDLE && state_d != DONE;
    rs_out_d = rw_d & rs_d;
    busy_d   = state_d != IDLE;
    done_d   = state_d == DONE;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      polls_q   <= '0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      e_q       <= 1'b0;
      rw_q      <= 1'b0;
      rs_out_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      polls_q   <= polls_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
      e_q       <= e_d;
      rw_q      <= rw_d;
      rs_out_q  <= rs_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign oBusy               = busy_q;
  assign oDone               = done_q;
  assign oData               = data_q;
  assign oBusyFlag           = data_q[7];
  assign oAddress            = data_q[6:0];
  assign oTimeout            = timeout_q;
  assign oLCD_Enabled        = e_q;
  assign oLCD_RegisterSelect = rs_out_q;
  assign oLCD_ReadWrite      = rw_q;
  assign oLCD_BusRelease     = rw_q;
endmodule

// File: tb/tb_lcd_status_reader.sv
// tb_lcd_status_reader: scoreboard bench with an LCD read model and a transaction-level reference.
module tb_lcd_status_reader;
  localparam int SU = 2, EH = 12, EL = 50, MP = 4;
  localparam int RD = SU + 2 * EH + 2 * EL;
  typedef struct {
    int start;
    int done;
    logic [7:0] data;
    logic to;
    int reads;
    logic rs;
  } exp_t;
  logic clk = 0, Reset = 1, iStart = 0, iRegisterSelect = 0, iPoll = 0;
  logic [3:0] iLCD_Data = 0;
  logic oBusy, oDone, oBusyFlag, oTimeout, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_BusRelease;
  logic [7:0] oData;
  logic [6:0] oAddress;
  int cyc = 0, checks = 0, failures = 0, idle_bad = 0;
  int pulses, width_bad, gap_bad, rw_bad, first_rise, hi_len, lo_len;
  exp_t sb[$];
  logic [7:0] lcd_q[$];
  lcd_status_reader #(.SETUP_CYCLES(SU), .E_HIGH_CYCLES(EH), .E_LOW_CYCLES(EL), .MAX_POLLS(MP)) dut (
    .Clock(clk), .Reset(Reset), .iStart(iStart), .iRegisterSelect(iRegisterSelect), .iPoll(iPoll),
    .iLCD_Data(iLCD_Data), .oBusy(oBusy), .oDone(oDone), .oData(oData), .oBusyFlag(oBusyFlag),
    .oAddress(oAddress), .oTimeout(oTimeout), .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_BusRelease(oLCD_BusRelease)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  // Reads repeat only for polled status reads while BF=1, up to MP reads in total.
  function automatic exp_t model(int c, logic rs, logic poll, logic [7:0] b[$]);
    exp_t e;
    int n = 0;
    logic [7:0] v;
    do begin
      v = b[(n < b.size()) ? n : b.size() - 1];
      n++;
    end while (!rs && poll && v[7] && n < MP);
    e.start = c;
    e.done  = c + 1 + RD * n;
    e.data  = v;
    e.to    = !rs && poll && v[7];
    e.reads = n;
    e.rs    = rs;
    return e;
  endfunction
  // LCD: valid nibble only in the last E-high cycle, noise otherwise.
  initial begin
    logic hi_phase = 1;
    int ecnt = 0;
    logic [7:0] cur = 0;
    forever begin
      @(negedge clk);
      if (!oLCD_ReadWrite) hi_phase = 1;
      ecnt = oLCD_Enabled ? ecnt + 1 : 0;
      if (oLCD_Enabled && ecnt == EH) begin
        if (hi_phase) begin
          if (lcd_q.size() > 1) cur = lcd_q.pop_front();
          else if (lcd_q.size() == 1) cur = lcd_q[0];
          else cur = 0;
          iLCD_Data = cur[7:4];
        end else iLCD_Data = cur[3:0];
        hi_phase = !hi_phase;
      end else iLCD_Data = 4'($urandom);
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (!Reset) begin
        if (sb.size() == 0) begin
          if (oBusy || oDone) idle_bad++;
        end else if (cyc > sb[0].start) begin
          if (cyc == sb[0].start + 1) begin
            pulses = 0; width_bad = 0; gap_bad = 0; rw_bad = 0;
            first_rise = -1; hi_len = 0; lo_len = 0;
          end
          if (oDone) begin
            chk("done_cycle", cyc, sb[0].done);
            chk("data", oData, sb[0].data);
            chk("busy_flag", oBusyFlag, sb[0].data[7]);
            chk("address", oAddress, sb[0].data[6:0]);
            chk("timeout", oTimeout, sb[0].to);
            chk("e_pulses", pulses, 2 * sb[0].reads);
            chk("e_width_bad", width_bad, 0);
            chk("e_gap_bad", gap_bad, 0);
            chk("bus_held_bad", rw_bad, 0);
            chk("first_e_rise", first_rise, sb[0].start + 1 + SU);
            chk("done_pins", {oLCD_Enabled, oLCD_ReadWrite, oLCD_RegisterSelect, oLCD_BusRelease, oBusy}, 5'b00001);
            void'(sb.pop_front());
          end else if (cyc > sb[0].done + 8) begin
            chk("done_seen", 0, 1);
            void'(sb.pop_front());
          end else begin
            if (cyc < sb[0].done && (oLCD_ReadWrite !== 1 || oLCD_BusRelease !== 1 || oBusy !== 1 ||
                oLCD_RegisterSelect !== sb[0].rs)) rw_bad++;
            if (oLCD_Enabled) begin
              if (hi_len == 0) begin
                pulses++;
                if (first_rise < 0) first_rise = cyc;
                if (pulses > 1 && lo_len != EL && lo_len != EL + SU) gap_bad++;
              end
              hi_len++;
              lo_len = 0;
            end else begin
              if (hi_len > 0 && hi_len != EH) width_bad++;
              hi_len = 0;
              lo_len++;
            end
          end
        end
      end
    end
  end
  task automatic wait_idle();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("idle_reached", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask
  task automatic start_txn(input logic rs, input logic poll, input logic [7:0] b[$], output exp_t e);
    wait_idle();
    lcd_q = b;
    e = model(cyc, rs, poll, b);
    sb.push_back(e);
    iRegisterSelect = rs;
    iPoll = poll;
    iStart = 1;
    @(negedge clk);
    iStart = 0;
    iRegisterSelect = 1'($urandom);
    iPoll = 1'($urandom);
  endtask
  initial begin
    exp_t e, e2;
    logic [7:0] bq[$];
    repeat (3) @(negedge clk);
    chk("reset_pins", {oBusy, oDone, oTimeout, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_BusRelease}, 0);
    chk("reset_data", oData, 8'h00);
    Reset = 0;
    bq.delete(); bq.push_back(8'h85);
    start_txn(0, 0, bq, e);
    bq.delete(); bq.push_back(8'h41);
    start_txn(1, 1, bq, e);
    bq.delete(); bq.push_back(8'hC1);
    start_txn(1, 1, bq, e);
    bq.delete(); bq.push_back(8'h8A); bq.push_back(8'h93); bq.push_back(8'hFF); bq.push_back(8'h0C);
    start_txn(0, 1, bq, e);
    bq.delete(); bq.push_back(8'h80);
    start_txn(0, 1, bq, e);
    // starts during EL_HI and in the DONE cycle must be dropped
    bq.delete(); bq.push_back(8'h27);
    start_txn(0, 0, bq, e);
    while (cyc < e.start + 1 + SU + EH + int'($urandom_range(0, EL - 1))) @(negedge clk);
    iStart = 1;
    @(negedge clk);
    iStart = 0;
    while (cyc < e.done) @(negedge clk);
    iStart = 1;
    @(negedge clk);
    iStart = 0;
    // iStart held high: second accept lands in the IDLE cycle after DONE
    wait_idle();
    bq.delete(); bq.push_back(8'h5A);
    e = model(cyc, 0, 0, bq);
    bq.delete(); bq.push_back(8'hA5);
    e2 = model(e.done + 1, 0, 0, bq);
    lcd_q.delete(); lcd_q.push_back(8'h5A); lcd_q.push_back(8'hA5);
    sb.push_back(e);
    sb.push_back(e2);
    iRegisterSelect = 0;
    iPoll = 0;
    iStart = 1;
    while (cyc < e2.start + 1) @(negedge clk);
    iStart = 0;
    // reset in the 5th EH_LO cycle
    bq.delete(); bq.push_back(8'h33);
    start_txn(0, 0, bq, e);
    while (cyc < e.start + 1 + SU + EH + EL + 4) @(negedge clk);
    chk("pre_reset_e", oLCD_Enabled, 1);
    Reset = 1;
    sb.delete();
    @(negedge clk);
    chk("mid_reset_pins", {oLCD_Enabled, oLCD_ReadWrite, oLCD_BusRelease, oBusy, oDone}, 0);
    chk("mid_reset_data", oData, 8'h00);
    Reset = 0;
    bq.delete(); bq.push_back(8'h9E); bq.push_back(8'h1F);
    start_txn(0, 1, bq, e);
    for (int i = 0; i < 12; i++) begin
      logic rs, poll;
      rs = 1'($urandom);
      poll = 1'($urandom);
      bq.delete();
      repeat ($urandom_range(0, 5)) bq.push_back({1'b1, 7'($urandom)});
      bq.push_back(8'($urandom));
      start_txn(rs, poll, bq, e);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("idle_quiet_bad", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
